// File: rtl/sysid_pkg.sv
// Shared definitions for the system-ID boot checker: FSM encoding, slave word
// addresses, the default build ID and the ID/timestamp match rule.
package sysid_pkg;

  typedef enum logic [2:0] {
    ST_WAIT,
    ST_RD_ID,
    ST_RD_TS,
    ST_EVAL,
    ST_DONE,
    ST_HRD
  } state_t;

  localparam logic        SYSID_ADDR_ID       = 1'b0;
  localparam logic        SYSID_ADDR_TS       = 1'b1;
  localparam logic [31:0] DEFAULT_EXPECTED_ID = 32'h2014_0213;

  // An expected timestamp of zero means the timestamp is not checked.
  function automatic logic id_match(input logic [31:0] id,
                                    input logic [31:0] ts,
                                    input logic [31:0] exp_id,
                                    input logic [31:0] exp_ts);
    return (id == exp_id) && ((exp_ts == 32'h0) || (ts == exp_ts));
  endfunction

endpackage

// File: rtl/sysid_start_delay.sv
// Post-reset delay timer: counts the cycles spent in WAIT and flags the last one
// so the checker leaves WAIT exactly START_DELAY cycles after reset release.
module sysid_start_delay #(
  parameter int START_DELAY = 16
) (
  input  logic clock,
  input  logic reset,
  input  logic en,
  output logic expired
);

  localparam int            W    = (START_DELAY > 1) ? $clog2(START_DELAY) : 1;
  localparam logic [W-1:0]  LAST = W'(START_DELAY - 1);

  logic [W-1:0] cnt;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (!en) begin
      cnt <= '0;
    end else if (!expired) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign expired = en && (cnt == LAST);

endmodule

// File: rtl/sysid_boot_checker.sv
// Reads and verifies the sysid slave after reset (with retries), publishes the
// result, then arbitrates the same slave for a host Avalon-MM reader.
module sysid_boot_checker
  import sysid_pkg::*;
#(
  parameter logic [31:0] EXPECTED_ID = DEFAULT_EXPECTED_ID,
  parameter logic [31:0] EXPECTED_TS = 32'h0000_0000,
  parameter int          START_DELAY = 16,
  parameter int          RETRY_MAX   = 3
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        avs_address,
  input  logic        avs_read,
  output logic        avs_waitrequest,
  output logic [31:0] avs_readdata,
  output logic        sysid_address,
  input  logic [31:0] sysid_readdata,
  input  logic        rescan,
  output logic        id_done,
  output logic        id_ok,
  output logic        id_error,
  output logic [31:0] timestamp
);

  localparam logic [3:0] RETRY_LIMIT = 4'(RETRY_MAX);

  state_t      state, state_d;
  logic        hrd_phase, hrd_phase_d;
  logic [3:0]  retries, retries_d;
  logic        done_d, ok_d, err_d;
  logic [31:0] id_q;
  logic        delay_en, delay_expired;

  assign delay_en = (state == ST_WAIT);

  sysid_start_delay #(
    .START_DELAY (START_DELAY)
  ) u_start_delay (
    .clock   (clock),
    .reset   (reset),
    .en      (delay_en),
    .expired (delay_expired)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= ST_WAIT;
      hrd_phase <= 1'b0;
      retries   <= '0;
      id_done   <= 1'b0;
      id_ok     <= 1'b0;
      id_error  <= 1'b0;
    end else begin
      state     <= state_d;
      hrd_phase <= hrd_phase_d;
      retries   <= retries_d;
      id_done   <= done_d;
      id_ok     <= ok_d;
      id_error  <= err_d;
    end
  end

  // NOTE: every output of this block is given a default before the case so no
  // path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_d         = state;
    hrd_phase_d     = 1'b0;
    retries_d       = retries;
    done_d          = id_done;
    ok_d            = id_ok;
    err_d           = id_error;
    sysid_address   = SYSID_ADDR_ID;
    avs_waitrequest = 1'b1;

    case (state)
      ST_WAIT: begin
        if (delay_expired) state_d = ST_RD_ID;
      end
      ST_RD_ID: begin
        state_d = ST_RD_TS;
      end
      ST_RD_TS: begin
        sysid_address = SYSID_ADDR_TS;
        state_d       = ST_EVAL;
      end
      ST_EVAL: begin
        if (id_match(id_q, timestamp, EXPECTED_ID, EXPECTED_TS)) begin
          done_d  = 1'b1;
          ok_d    = 1'b1;
          err_d   = 1'b0;
          state_d = ST_DONE;
        end else if (retries < RETRY_LIMIT) begin
          retries_d = retries + 1'b1;
          state_d   = ST_RD_ID;
        end else begin
          done_d  = 1'b1;
          ok_d    = 1'b0;
          err_d   = 1'b1;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        // rescan beats a simultaneous host read; the read stays stalled.
        if (rescan) begin
          done_d    = 1'b0;
          ok_d      = 1'b0;
          err_d     = 1'b0;
          retries_d = '0;
          state_d   = ST_RD_ID;
        end else if (avs_read) begin
          state_d = ST_HRD;
        end
      end
      ST_HRD: begin
        if (!hrd_phase) begin
          sysid_address = avs_address;
          hrd_phase_d   = 1'b1;
        end else begin
          avs_waitrequest = 1'b0;
          state_d         = ST_DONE;
        end
      end
      default: begin
        state_d = ST_WAIT;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      id_q         <= '0;
      timestamp    <= '0;
      avs_readdata <= '0;
    end else begin
      if (state == ST_RD_ID)                id_q         <= sysid_readdata;
      if (state == ST_RD_TS)                timestamp    <= sysid_readdata;
      if ((state == ST_HRD) && !hrd_phase)  avs_readdata <= sysid_readdata;
    end
  end

endmodule

// File: tb/tb_sysid_boot_checker.sv
// Self-checking bench for sysid_boot_checker: boot timing, retries, host reads
// through a scoreboard, rescan arbitration and reset during a host read.
module tb_sysid_boot_checker;

  localparam int          S       = 16;
  localparam logic [31:0] GOOD_ID = 32'h2014_0213;
  localparam logic [31:0] GOOD_TS = 32'h5467_E0C3;
  localparam logic [31:0] BAD_ID  = 32'hDEAD_BEEF;
  localparam logic [31:0] NEW_TS  = 32'h1234_5678;

  logic        clock;
  logic        reset;
  logic        avs_address;
  logic        avs_read;
  logic        avs_waitrequest;
  logic [31:0] avs_readdata;
  logic        sysid_address;
  logic [31:0] sysid_readdata;
  logic        rescan;
  logic        id_done;
  logic        id_ok;
  logic        id_error;
  logic [31:0] timestamp;

  sysid_boot_checker #(
    .EXPECTED_ID (GOOD_ID),
    .EXPECTED_TS (32'h0),
    .START_DELAY (S),
    .RETRY_MAX   (3)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .avs_address     (avs_address),
    .avs_read        (avs_read),
    .avs_waitrequest (avs_waitrequest),
    .avs_readdata    (avs_readdata),
    .sysid_address   (sysid_address),
    .sysid_readdata  (sysid_readdata),
    .rescan          (rescan),
    .id_done         (id_done),
    .id_ok           (id_ok),
    .id_error        (id_error),
    .timestamp       (timestamp)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Sysid slave model; optionally returns a bad ID on the first boot read only.
  logic [31:0] model_id = GOOD_ID;
  logic [31:0] model_ts = GOOD_TS;
  logic        bad_first = 1'b0;
  int          ts_reads = 0;
  int          ts_base  = 0;
  int          cyc;

  always_comb begin
    if (sysid_address) sysid_readdata = model_ts;
    else if (bad_first && (ts_reads == ts_base)) sysid_readdata = BAD_ID;
    else sysid_readdata = model_id;
  end

  always @(posedge clock) if (sysid_address) ts_reads <= ts_reads + 1;

  always @(posedge clock or posedge reset) begin
    if (reset) cyc <= 0;
    else cyc <= cyc + 1;
  end

  int          checks = 0;
  int          errors = 0;
  logic [31:0] sb[$];

  typedef struct {
    logic        addr;
    logic [31:0] id_val;
    logic [31:0] ts_val;
    logic [31:0] exp;
  } vec_t;
  vec_t vecs[4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_waitreq"},  {31'b0, avs_waitrequest}, 32'd1);
    check({tag, "_rdata"},    avs_readdata,              32'd0);
    check({tag, "_saddr"},    {31'b0, sysid_address},    32'd0);
    check({tag, "_done"},     {31'b0, id_done},          32'd0);
    check({tag, "_ok"},       {31'b0, id_ok},            32'd0);
    check({tag, "_err"},      {31'b0, id_error},         32'd0);
    check({tag, "_ts"},       timestamp,                 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset    = 1'b1;
    avs_read = 1'b0;
    rescan   = 1'b0;
    repeat (2) @(negedge clock);
    reset   = 1'b0;
    ts_base = ts_reads;
  endtask

  task automatic wait_done(input int budget);
    while (!id_done && cyc < budget) @(negedge clock);
    check("done_seen", {31'b0, id_done}, 32'd1);
  endtask

  task automatic start_read(input logic addr, input logic [31:0] exp);
    avs_address = addr;
    avs_read    = 1'b1;
    sb.push_back(exp);
  endtask

  task automatic wait_read(input int budget, output int lat);
    logic [31:0] exp;
    lat = 0;
    while (avs_waitrequest && lat < budget) begin
      @(negedge clock);
      lat++;
    end
    check("hrd_wait", {31'b0, avs_waitrequest}, 32'd0);
    if (!avs_waitrequest) begin
      check("sb_nonempty", {31'b0, sb.size() != 0}, 32'd1);
      if (sb.size() != 0) begin
        exp = sb.pop_front();
        check("hrd_data", avs_readdata, exp);
      end
    end else if (sb.size() != 0) begin
      void'(sb.pop_front());
    end
    @(posedge clock);
    #1;
    avs_read = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired at t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;

    vecs[0] = '{addr: 1'b0, id_val: GOOD_ID,      ts_val: GOOD_TS,      exp: 32'h2014_0213};
    vecs[1] = '{addr: 1'b1, id_val: GOOD_ID,      ts_val: GOOD_TS,      exp: 32'h5467_E0C3};
    vecs[2] = '{addr: 1'b1, id_val: 32'hA5A5_0000, ts_val: 32'hFFFF_FFFF, exp: 32'hFFFF_FFFF};
    vecs[3] = '{addr: 1'b0, id_val: 32'h0F0F_1234, ts_val: 32'h0000_0001, exp: 32'h0F0F_1234};

    reset       = 1'b1;
    avs_address = 1'b0;
    avs_read    = 1'b0;
    rescan      = 1'b0;
    repeat (3) @(negedge clock);
    check_reset_vals("rst");
    reset   = 1'b0;
    ts_base = ts_reads;

    // Clean boot: done exactly START_DELAY+3 cycles after release.
    wait_done(200);
    check("boot_cyc", 32'(cyc), 32'(S + 3));
    check("boot_ok",  {31'b0, id_ok},    32'd1);
    check("boot_err", {31'b0, id_error}, 32'd0);
    check("boot_ts",  timestamp,         GOOD_TS);

    // Host reads in DONE, fixed 2-cycle latency.
    foreach (vecs[i]) begin
      @(negedge clock);
      model_id = vecs[i].id_val;
      model_ts = vecs[i].ts_val;
      start_read(vecs[i].addr, vecs[i].exp);
      wait_read(10, lat);
      check("hrd_lat", 32'(lat), 32'd2);
    end
    check("status_hold_ok", {31'b0, id_ok}, 32'd1);

    // rescan together with a host read: rescan wins, read served after new DONE.
    @(negedge clock);
    model_id = GOOD_ID;
    model_ts = NEW_TS;
    start_read(1'b0, GOOD_ID);
    rescan = 1'b1;
    @(negedge clock);
    rescan = 1'b0;
    check("rescan_done_low", {31'b0, id_done}, 32'd0);
    check("rescan_ts_hold",  timestamp,        GOOD_TS);
    check("rescan_waitreq",  {31'b0, avs_waitrequest}, 32'd1);
    wait_read(20, lat);
    check("rescan_lat",  32'(lat + 1), 32'd6);
    check("rescan_done", {31'b0, id_done}, 32'd1);
    check("rescan_ok",   {31'b0, id_ok},   32'd1);
    check("rescan_ts",   timestamp,        NEW_TS);

    // Reset during HRD cycle 1: read abandoned, full restart with START_DELAY.
    @(negedge clock);
    model_ts = GOOD_TS;
    start_read(1'b0, GOOD_ID);
    @(negedge clock);
    check("hrd1_waitreq", {31'b0, avs_waitrequest}, 32'd1);
    reset    = 1'b1;
    avs_read = 1'b0;
    void'(sb.pop_back());
    #1;
    check_reset_vals("midrst");
    @(negedge clock);
    reset   = 1'b0;
    ts_base = ts_reads;
    while (cyc < 5) @(negedge clock);
    rescan = 1'b1;   // in WAIT: must be ignored
    @(negedge clock);
    rescan = 1'b0;
    wait_done(200);
    check("restart_cyc", 32'(cyc), 32'(S + 3));
    check("restart_ok",  {31'b0, id_ok}, 32'd1);

    // Persistent bad ID: 1 + RETRY_MAX reads, then error.
    model_id = BAD_ID;
    do_reset();
    wait_done(200);
    check("bad_cyc",   32'(cyc), 32'(S + 12));
    check("bad_err",   {31'b0, id_error}, 32'd1);
    check("bad_ok",    {31'b0, id_ok},    32'd0);
    check("bad_reads", 32'(ts_reads - ts_base), 32'd4);
    model_id = GOOD_ID;

    // Bad ID on first read only: one retry then pass.
    bad_first = 1'b1;
    do_reset();
    wait_done(200);
    check("retry_cyc",   32'(cyc), 32'(S + 6));
    check("retry_ok",    {31'b0, id_ok},    32'd1);
    check("retry_err",   {31'b0, id_error}, 32'd0);
    check("retry_reads", 32'(ts_reads - ts_base), 32'd2);
    bad_first = 1'b0;

    // Host read issued two cycles after reset: stalled until DONE+2.
    do_reset();
    while (cyc < 2) @(negedge clock);
    start_read(1'b1, GOOD_TS);
    wait_read(100, lat);
    check("early_lat",  32'(lat), 32'(S + 3));
    check("early_done", {31'b0, id_done}, 32'd1);

    check("sb_empty", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
